// File: rtl/constraint_sample_driver_if.sv
// Handshake and data bundle between the candidate sampler and its environment.
// The fix_mask_i/fix_val_i signals exist only when SAMPLER_FIX_EN is defined.
interface constraint_sample_driver_if #(
  parameter int TOTAL_W = 551
);
  logic               start_i;
  logic [31:0]        seed_i;
  logic [15:0]        max_tries_i;
  logic [TOTAL_W-1:0] cand_o;
  logic               cand_valid_o;
  logic               sat_i;
  logic               busy_o;
  logic               res_valid_o;
  logic               res_ready_i;
  logic               found_o;
  logic [TOTAL_W-1:0] sol_o;
  logic [15:0]        tries_o;
`ifdef SAMPLER_FIX_EN
  logic [TOTAL_W-1:0] fix_mask_i;
  logic [TOTAL_W-1:0] fix_val_i;
`endif

  // master is the sampler itself; slave is the side that starts searches and checks candidates.
  modport master (
    input  start_i, seed_i, max_tries_i, sat_i, res_ready_i,
`ifdef SAMPLER_FIX_EN
    input  fix_mask_i, fix_val_i,
`endif
    output cand_o, cand_valid_o, busy_o, res_valid_o, found_o, sol_o, tries_o
  );

  modport slave (
    output start_i, seed_i, max_tries_i, sat_i, res_ready_i,
`ifdef SAMPLER_FIX_EN
    output fix_mask_i, fix_val_i,
`endif
    input  cand_o, cand_valid_o, busy_o, res_valid_o, found_o, sol_o, tries_o
  );
endinterface

// File: rtl/constraint_sample_driver.sv
// LFSR-driven candidate generator that retries against the constraint checker until success or budget.
// Define SAMPLER_FIX_EN to pin selected candidate bits to captured fixed values.
module constraint_sample_driver #(
  parameter int TOTAL_W = 551,
  parameter int CHK_LAT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  constraint_sample_driver_if.master bus
);
  localparam int              WORDS     = (TOTAL_W + 31) / 32;
  localparam int              IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);
  localparam logic [2:0]      LAT_END   = 3'(CHK_LAT);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_RESULT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_next, fill_word;
  logic [IDX_W-1:0]   word_q;
  logic [2:0]         lat_q;
  logic [15:0]        budget_q, tries_q, tries_inc;
  logic [TOTAL_W-1:0] cand_q, sol_q, word_mask, word_data;
  logic               found_q;
  logic               start_ok, last_word, sample, budget_hit;

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

`ifdef SAMPLER_FIX_EN
  logic [TOTAL_W-1:0] fix_mask_q, fix_val_q;
  logic [31:0]        fix_mask_w, fix_val_w;

  assign fix_mask_w = 32'(fix_mask_q >> {word_q, 5'b0});
  assign fix_val_w  = 32'(fix_val_q >> {word_q, 5'b0});
  assign fill_word  = (lfsr_q & ~fix_mask_w) | (fix_val_w & fix_mask_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fix_mask_q <= '0;
      fix_val_q  <= '0;
    end else if (start_ok) begin
      fix_mask_q <= bus.fix_mask_i;
      fix_val_q  <= bus.fix_val_i;
    end
  end
`else
  assign fill_word = lfsr_q;
`endif

  // Shifting a full-width mask lets the top word truncate itself at TOTAL_W.
  assign word_mask  = TOTAL_W'(32'hFFFF_FFFF) << {word_q, 5'b0};
  assign word_data  = TOTAL_W'(fill_word) << {word_q, 5'b0};

  assign start_ok   = (state_q == S_IDLE) && bus.start_i;
  assign last_word  = (word_q == LAST_WORD);
  assign sample     = (state_q == S_CHECK) && (lat_q == LAT_END);
  assign tries_inc  = (tries_q == 16'hFFFF) ? tries_q : tries_q + 16'd1;
  assign budget_hit = (budget_q != 16'd0) && (tries_inc == budget_q);

  always_comb begin
    // NOTE: assign the default first so no path leaves state_d unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start_i) state_d = S_FILL;
      S_FILL:   if (last_word) state_d = S_CHECK;
      S_CHECK:  if (sample) state_d = (bus.sat_i || budget_hit) ? S_RESULT : S_FILL;
      S_RESULT: if (bus.res_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // NOTE: the wide candidate and solution registers are reset as well, so every output reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= 32'h1;
      word_q   <= '0;
      lat_q    <= '0;
      budget_q <= '0;
      tries_q  <= '0;
      cand_q   <= '0;
      sol_q    <= '0;
      found_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        lfsr_q   <= (bus.seed_i == 32'h0) ? 32'h1 : bus.seed_i;
        budget_q <= bus.max_tries_i;
        tries_q  <= '0;
        found_q  <= 1'b0;
        word_q   <= '0;
      end
      if (state_q == S_FILL) begin
        cand_q <= (cand_q & ~word_mask) | word_data;
        lfsr_q <= lfsr_next;
        word_q <= last_word ? '0 : word_q + IDX_W'(1);
        lat_q  <= '0;
      end
      if ((state_q == S_CHECK) && !sample) lat_q <= lat_q + 3'd1;
      if (sample) begin
        tries_q <= tries_inc;
        if (bus.sat_i) begin
          sol_q   <= cand_q;
          found_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cand_o       = cand_q;
  assign bus.cand_valid_o = (state_q == S_CHECK);
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.res_valid_o  = (state_q == S_RESULT);
  assign bus.found_o      = found_q;
  assign bus.sol_o        = sol_q;
  assign bus.tries_o      = tries_q;
endmodule

// File: tb/tb_constraint_sample_driver.sv
// Directed-plus-random bench for constraint_sample_driver with a candidate-sequence reference model.
// Two instances: a combinational-checker build and a three-cycle-latency build.
module tb_constraint_sample_driver;
  localparam int TOTAL_W = 551;
  localparam int WORDS   = (TOTAL_W + 31) / 32;
  localparam int LAT0    = 0;
  localparam int LAT1    = 3;
  localparam int CW      = 640;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   sat_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  constraint_sample_driver_if #(.TOTAL_W(TOTAL_W)) bus0 ();
  constraint_sample_driver_if #(.TOTAL_W(TOTAL_W)) bus1 ();

  constraint_sample_driver #(.TOTAL_W(TOTAL_W), .CHK_LAT(LAT0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  constraint_sample_driver #(.TOTAL_W(TOTAL_W), .CHK_LAT(LAT1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

`ifdef SAMPLER_FIX_EN
  localparam logic [TOTAL_W-1:0] FIX_MASK = TOTAL_W'(4'hF);
  localparam logic [TOTAL_W-1:0] FIX_VAL  = TOTAL_W'(4'hA);
  assign bus0.fix_mask_i = FIX_MASK;
  assign bus0.fix_val_i  = FIX_VAL;
  assign bus1.fix_mask_i = FIX_MASK;
  assign bus1.fix_val_i  = FIX_VAL;

  int fix_seen = 0;
  int fix_bad  = 0;
  always @(negedge clk) begin
    if (bus0.cand_valid_o) begin
      fix_seen <= fix_seen + 1;
      if (bus0.cand_o[3:0] != 4'hA) fix_bad <= fix_bad + 1;
    end
  end
`else
  localparam logic [TOTAL_W-1:0] FIX_MASK = '0;
  localparam logic [TOTAL_W-1:0] FIX_VAL  = '0;
`endif

  // Checker stubs: dut0 sees a combinational checker, dut1 a three-stage pipelined one.
  assign bus0.sat_i = (sat_mode == 1) || ((sat_mode == 2) && (bus0.cand_o[9:5] == 5'd0));

  logic [TOTAL_W-1:0] target1  = '0;
  logic [2:0]         sat_pipe = '0;
  always @(posedge clk) sat_pipe <= {sat_pipe[1:0], bus1.cand_valid_o && (bus1.cand_o == target1)};
  assign bus1.sat_i = sat_pipe[2];

  // A candidate change right after a valid cycle means the vector was flagged valid while filling.
  bit                 mon1        = 1'b0;
  int                 viol1       = 0;
  int                 vcnt1       = 0;
  logic               prev_valid1 = 1'b0;
  logic [TOTAL_W-1:0] prev_cand1  = '0;
  always @(negedge clk) begin
    prev_valid1 <= bus1.cand_valid_o;
    prev_cand1  <= bus1.cand_o;
    if (mon1) begin
      if (bus1.cand_valid_o) vcnt1 <= vcnt1 + 1;
      if (prev_valid1 && (bus1.cand_o != prev_cand1)) viol1 <= viol1 + 1;
    end
  end

  logic [31:0] m_lfsr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_next_cand(output logic [TOTAL_W-1:0] c);
    logic [WORDS*32-1:0] pad;
    for (int k = 0; k < WORDS; k++) begin
      pad[k*32 +: 32] = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
    end
    c = pad[TOTAL_W-1:0];
    c = (c & ~FIX_MASK) | (FIX_VAL & FIX_MASK);
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero0(input string tag);
    check({tag, " busy"},       CW'(bus0.busy_o),       CW'(1'b0));
    check({tag, " cand_valid"}, CW'(bus0.cand_valid_o), CW'(1'b0));
    check({tag, " res_valid"},  CW'(bus0.res_valid_o),  CW'(1'b0));
    check({tag, " found"},      CW'(bus0.found_o),      CW'(1'b0));
    check({tag, " tries"},      CW'(bus0.tries_o),      CW'(16'h0));
    check({tag, " cand"},       CW'(bus0.cand_o),       CW'(0));
    check({tag, " sol"},        CW'(bus0.sol_o),        CW'(0));
  endtask

  // mode 0: checker never satisfied, 1: always satisfied, 2: satisfied when cand[9:5] == 0.
  task automatic run0(input string tag, input logic [31:0] seed, input logic [15:0] budget,
                      input int mode, input bit hold);
    logic [TOTAL_W-1:0] c, last_c, exp_sol;
    int                 exp_tries, t0, lat, limit, unstable;
    bit                 exp_found;
    m_lfsr    = (seed == 32'h0) ? 32'h1 : seed;
    exp_tries = 0;
    exp_found = 1'b0;
    exp_sol   = '0;
    last_c    = '0;
    while (1) begin
      model_next_cand(c);
      exp_tries++;
      last_c = c;
      if ((mode == 1) || ((mode == 2) && (c[9:5] == 5'd0))) begin
        exp_found = 1'b1;
        exp_sol   = c;
        break;
      end
      if ((budget != 16'd0) && (exp_tries == int'(budget))) break;
    end

    sat_mode = mode;
    @(negedge clk);
    bus0.seed_i      = seed;
    bus0.max_tries_i = budget;
    bus0.start_i     = 1'b1;
    t0               = cyc;
    @(negedge clk);
    bus0.start_i = 1'b0;
    check({tag, " busy_rise"}, CW'(bus0.busy_o), CW'(1'b1));
    limit = exp_tries * (WORDS + LAT0 + 1) + 20;
    while (!bus0.res_valid_o && ((cyc - t0) < limit)) @(negedge clk);
    lat = cyc - t0;
    check({tag, " latency"}, CW'(lat), CW'(exp_tries * (WORDS + LAT0 + 1) + 1));
    check({tag, " found"},   CW'(bus0.found_o), CW'(exp_found));
    check({tag, " tries"},   CW'(bus0.tries_o), CW'(16'(exp_tries)));
    check({tag, " cand"},    CW'(bus0.cand_o),  CW'(last_c));
    if (exp_found) check({tag, " sol"}, CW'(bus0.sol_o), CW'(exp_sol));

    if (hold) begin
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
        bus0.start_i = (i == 5);
        bus0.seed_i  = ~seed;
        @(negedge clk);
        if (!bus0.res_valid_o || (bus0.sol_o !== exp_sol) || (bus0.cand_o !== last_c) ||
            (bus0.tries_o !== 16'(exp_tries)) || (bus0.found_o !== exp_found)) unstable++;
      end
      bus0.start_i = 1'b0;
      check({tag, " result_stable"}, CW'(unstable), CW'(0));
    end

    bus0.res_ready_i = 1'b1;
    bus0.start_i     = hold;
    @(negedge clk);
    bus0.res_ready_i = 1'b0;
    bus0.start_i     = 1'b0;
    check({tag, " res_valid_drop"}, CW'(bus0.res_valid_o), CW'(1'b0));
    check({tag, " busy_fall"},      CW'(bus0.busy_o),      CW'(1'b0));
  endtask

  initial begin
    logic [31:0]        s, w0;
    logic [15:0]        budget;
    logic [TOTAL_W-1:0] c;
    int                 t0, mode;

    bus0.start_i = 1'b0; bus0.seed_i = '0; bus0.max_tries_i = '0; bus0.res_ready_i = 1'b0;
    bus1.start_i = 1'b0; bus1.seed_i = '0; bus1.max_tries_i = '0; bus1.res_ready_i = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero0("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero0("post_reset");

    // Seed 0 maps to 1, so the first word is the LFSR value 1 (with any pinned bits applied).
    run0("first_try", 32'h0, 16'd0, 1, 1'b0);
    w0 = (32'h1 & ~FIX_MASK[31:0]) | (FIX_VAL[31:0] & FIX_MASK[31:0]);
    check("seed0 word0", CW'(bus0.cand_o[31:0]), CW'(w0));

    run0("budget3", $urandom, 16'd3, 0, 1'b0);
    run0("hold", $urandom, 16'd0, 1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      budget = (i == 4) ? 16'd0 : 16'($urandom_range(1, 12));
      mode   = ((i % 3) == 2) ? 0 : 2;
      run0($sformatf("rand%0d", i), $urandom, budget, mode, 1'b0);
    end

    // Latency-3 checker that only accepts the fifth candidate.
    s      = $urandom;
    m_lfsr = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < 5; k++) model_next_cand(c);
    target1 = c;
    @(negedge clk);
    mon1             = 1'b1;
    bus1.seed_i      = s;
    bus1.max_tries_i = 16'd0;
    bus1.start_i     = 1'b1;
    t0               = cyc;
    @(negedge clk);
    bus1.start_i = 1'b0;
    while (!bus1.res_valid_o && ((cyc - t0) < 5 * (WORDS + LAT1 + 1) + 20)) @(negedge clk);
    check("lat3 latency", CW'(cyc - t0), CW'(5 * (WORDS + LAT1 + 1) + 1));
    mon1 = 1'b0;
    check("lat3 tries",       CW'(bus1.tries_o), CW'(16'd5));
    check("lat3 found",       CW'(bus1.found_o), CW'(1'b1));
    check("lat3 sol",         CW'(bus1.sol_o),   CW'(target1));
    check("lat3 valid_cycles", CW'(vcnt1),       CW'(5 * (LAT1 + 1)));
    check("lat3 valid_in_fill", CW'(viol1),      CW'(0));
    bus1.res_ready_i = 1'b1;
    @(negedge clk);
    bus1.res_ready_i = 1'b0;
    check("lat3 busy_fall", CW'(bus1.busy_o), CW'(1'b0));

    // Asynchronous reset in the fill phase of the second try.
    s        = $urandom;
    sat_mode = 0;
    @(negedge clk);
    bus0.seed_i      = s;
    bus0.max_tries_i = 16'd5;
    bus0.start_i     = 1'b1;
    t0               = cyc;
    @(negedge clk);
    bus0.start_i = 1'b0;
    while ((cyc - t0) < (WORDS + LAT0 + 1 + 4)) @(negedge clk);
    check("pre_reset tries", CW'(bus0.tries_o), CW'(16'd1));
    check("pre_reset busy",  CW'(bus0.busy_o),  CW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check_zero0("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run0("reseed", s, 16'd1, 1, 1'b0);

`ifdef SAMPLER_FIX_EN
    check("fix seen",   CW'(fix_seen > 0), CW'(1'b1));
    check("fix pinned", CW'(fix_bad),      CW'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
